// File: rtl/sva_sched_pkg.sv
// Shared types, state encodings and width helpers for the assertion-attempt scheduler.
package sva_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Bits needed to hold a popcount of n completion pulses.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed for an age counter that must reach timeout-1.
  function automatic int age_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/sva_slot_tracker.sv
// One checker slot: occupancy bit plus watchdog age counter with combinational abort.
module sva_slot_tracker
  import sva_sched_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic pass,
  input  logic fail,
  output logic busy,
  output logic abort
);

  localparam int AGE_W = age_width(TIMEOUT);

  logic             busy_reg;
  logic [AGE_W-1:0] age_reg;

  // A completion arriving on the expiry cycle suppresses the abort.
  assign abort = busy_reg & ~pass & ~fail & (age_reg == AGE_W'(TIMEOUT - 1));
  assign busy  = busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      age_reg  <= '0;
    end else if (start) begin
      busy_reg <= 1'b1;
      age_reg  <= '0;
    end else if (busy_reg && (pass || fail || abort)) begin
      busy_reg <= 1'b0;
      age_reg  <= '0;
    end else if (busy_reg) begin
      age_reg  <= age_reg + AGE_W'(1);
    end
  end

endmodule

// File: rtl/sva_attempt_scheduler.sv
// Dispatches overlapping assertion attempts onto a pool of checker slots and aggregates results.
module sva_attempt_scheduler
  import sva_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 trigger,
  input  logic                 clear_counts,
  input  logic [NUM_SLOTS-1:0] slot_pass,
  input  logic [NUM_SLOTS-1:0] slot_fail,
  output logic [NUM_SLOTS-1:0] slot_start,
  output logic [NUM_SLOTS-1:0] slot_abort,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic [CNT_W-1:0]     timeout_count,
  output logic                 any_fail,
  output logic                 busy
);

  localparam int INC_W = cnt_width(NUM_SLOTS);

  logic [NUM_SLOTS:0]   all_below;
  logic                 request;
  logic                 drop;
  logic [NUM_SLOTS-1:0] pass_v;
  logic [NUM_SLOTS-1:0] fail_v;
  logic [INC_W-1:0]     pass_inc;
  logic [INC_W-1:0]     fail_inc;
  logic [INC_W-1:0]     timeout_inc;
  logic [1:0]           state_reg;
  logic [1:0]           state_next;

  // Gated by rst_n so the start strobes are also quiet while reset is held.
  assign request      = enable & trigger & rst_n;
  assign all_below[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign all_below[gi+1] = all_below[gi] & slot_busy[gi];
      assign slot_start[gi]  = request & ~slot_busy[gi] & all_below[gi];

      sva_slot_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (slot_start[gi]),
        .pass  (slot_pass[gi]),
        .fail  (slot_fail[gi]),
        .busy  (slot_busy[gi]),
        .abort (slot_abort[gi])
      );
    end
  endgenerate

  assign drop   = request & all_below[NUM_SLOTS];
  assign fail_v = slot_fail & slot_busy;
  assign pass_v = slot_pass & slot_busy & ~slot_fail;

  always_comb begin
    pass_inc    = '0;
    fail_inc    = '0;
    timeout_inc = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pass_inc    = pass_inc    + INC_W'(pass_v[i]);
      fail_inc    = fail_inc    + INC_W'(fail_v[i]);
      timeout_inc = timeout_inc + INC_W'(slot_abort[i]);
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count    <= '0;
      fail_count    <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
      any_fail      <= 1'b0;
    end else if (clear_counts) begin
      pass_count    <= '0;
      fail_count    <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
      any_fail      <= 1'b0;
    end else begin
      pass_count    <= sat_add(pass_count, pass_inc);
      fail_count    <= sat_add(fail_count, fail_inc);
      drop_count    <= sat_add(drop_count, INC_W'(drop));
      timeout_count <= sat_add(timeout_count, timeout_inc);
      if (fail_inc != '0 || timeout_inc != '0) any_fail <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_RUN;
      ST_RUN:   if (!enable) state_next = (slot_busy != '0) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (enable)                 state_next = ST_RUN;
        else if (slot_busy == '0)   state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sva_attempt_scheduler.sv
// Directed scenario bench for sva_attempt_scheduler (4 slots, 16-bit counters, timeout 8).
module tb_sva_attempt_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic        clear_counts = 1'b0;
  logic [3:0]  slot_pass = '0;
  logic [3:0]  slot_fail = '0;
  logic [3:0]  slot_start, slot_abort, slot_busy;
  logic [15:0] pass_count, fail_count, drop_count, timeout_count;
  logic        any_fail, busy;

  int checks = 0;
  int failures = 0;

  sva_attempt_scheduler #(.NUM_SLOTS(4), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger), .clear_counts(clear_counts),
    .slot_pass(slot_pass), .slot_fail(slot_fail), .slot_start(slot_start), .slot_abort(slot_abort),
    .slot_busy(slot_busy), .pass_count(pass_count), .fail_count(fail_count), .drop_count(drop_count),
    .timeout_count(timeout_count), .any_fail(any_fail), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (slot_busy !== 4'b0 || slot_abort !== 4'b0 || slot_start !== 4'b0) begin failures++; $display("FAIL reset_slots busy=%b abort=%b start=%b exp=0", slot_busy, slot_abort, slot_start); end
    checks++; if ({pass_count, fail_count, drop_count, timeout_count} !== 64'd0) begin failures++; $display("FAIL reset_counts got=%h exp=0", {pass_count, fail_count, drop_count, timeout_count}); end
    checks++; if (any_fail !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags any_fail=%b busy=%b exp=0", any_fail, busy); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    enable = 1'b1; trigger = 1'b1;
    #1;
    checks++; if (slot_start !== 4'b0001) begin failures++; $display("FAIL single_start got=%b exp=0001", slot_start); end
    tick();
    trigger = 1'b0;
    checks++; if (slot_busy !== 4'b0001) begin failures++; $display("FAIL single_busy got=%b exp=0001", slot_busy); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_fsm_run got=%b exp=1", busy); end
    slot_pass = 4'b0001;
    tick();
    slot_pass = 4'b0000;
    checks++; if (pass_count !== 16'd1) begin failures++; $display("FAIL single_pass_count got=%0d exp=1", pass_count); end
    checks++; if (slot_busy !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", slot_busy); end
    $display("test_single done pass_count=%0d", pass_count);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    for (int i = 0; i < 5; i++) begin
      trigger = 1'b1;
      #1;
      exp = (i < 4) ? 4'(1 << i) : 4'b0000;
      checks++; if (slot_start !== exp) begin failures++; $display("FAIL b2b_start%0d got=%b exp=%b", i, slot_start, exp); end
      tick();
    end
    trigger = 1'b0;
    checks++; if (drop_count !== 16'd1) begin failures++; $display("FAIL b2b_drop got=%0d exp=1", drop_count); end
    checks++; if (slot_busy !== 4'b1111) begin failures++; $display("FAIL b2b_busy got=%b exp=1111", slot_busy); end
    slot_pass = 4'b1111;
    tick();
    slot_pass = 4'b0000;
    checks++; if (pass_count !== 16'd5) begin failures++; $display("FAIL b2b_pass_popcount got=%0d exp=5", pass_count); end
    checks++; if (slot_busy !== 4'b0000) begin failures++; $display("FAIL b2b_release got=%b exp=0000", slot_busy); end
    $display("test_back_to_back done drop_count=%0d pass_count=%0d", drop_count, pass_count);
  endtask

  task automatic test_dual_fail();
    trigger = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    clear_counts = 1'b1;
    tick();
    trigger = 1'b0; clear_counts = 1'b0;
    checks++; if (drop_count !== 16'd0 || pass_count !== 16'd0) begin failures++; $display("FAIL clear_priority drop=%0d pass=%0d exp=0,0", drop_count, pass_count); end
    slot_pass = 4'b0111; slot_fail = 4'b1010;
    tick();
    slot_pass = 4'b0000; slot_fail = 4'b0000;
    checks++; if (fail_count !== 16'd2) begin failures++; $display("FAIL dual_fail_count got=%0d exp=2", fail_count); end
    checks++; if (pass_count !== 16'd2) begin failures++; $display("FAIL pass_and_fail_is_fail got=%0d exp=2", pass_count); end
    checks++; if (any_fail !== 1'b1) begin failures++; $display("FAIL dual_any_fail got=%b exp=1", any_fail); end
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    checks++; if ({pass_count, fail_count, drop_count, timeout_count} !== 64'd0 || any_fail !== 1'b0) begin failures++; $display("FAIL clear_all counts=%h any_fail=%b exp=0", {pass_count, fail_count, drop_count, timeout_count}, any_fail); end
    slot_pass = 4'b1111;
    tick();
    slot_pass = 4'b0000;
    checks++; if (pass_count !== 16'd0) begin failures++; $display("FAIL spurious_pass got=%0d exp=0", pass_count); end
    $display("test_dual_fail done");
  endtask

  task automatic test_timeout();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      checks++; if (slot_abort !== ((k == 8) ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL abort_cycle%0d got=%b", k, slot_abort); end
      tick();
    end
    checks++; if (slot_busy !== 4'b0000) begin failures++; $display("FAIL abort_release got=%b exp=0000", slot_busy); end
    checks++; if (timeout_count !== 16'd1 || any_fail !== 1'b1) begin failures++; $display("FAIL timeout_count got=%0d any_fail=%b exp=1,1", timeout_count, any_fail); end
    trigger = 1'b1;
    #1;
    checks++; if (slot_start !== 4'b0001) begin failures++; $display("FAIL reuse_start got=%b exp=0001", slot_start); end
    tick();
    trigger = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      slot_pass = (k == 8) ? 4'b0001 : 4'b0000;
      #1;
      checks++; if (slot_abort !== 4'b0000) begin failures++; $display("FAIL completion_wins%0d got=%b exp=0000", k, slot_abort); end
      tick();
    end
    slot_pass = 4'b0000;
    checks++; if (pass_count !== 16'd1 || timeout_count !== 16'd1) begin failures++; $display("FAIL completion_counts pass=%0d timeout=%0d exp=1,1", pass_count, timeout_count); end
    $display("test_timeout done timeout_count=%0d", timeout_count);
  endtask

  task automatic test_drain();
    trigger = 1'b1;
    tick(); tick();
    enable = 1'b0;
    #1;
    checks++; if (slot_start !== 4'b0000) begin failures++; $display("FAIL drain_no_start got=%b exp=0000", slot_start); end
    tick();
    checks++; if (busy !== 1'b1 || slot_busy !== 4'b0011) begin failures++; $display("FAIL drain_state busy=%b slots=%b exp=1,0011", busy, slot_busy); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL drain_drop got=%0d exp=0", drop_count); end
    slot_pass = 4'b0011;
    tick();
    slot_pass = 4'b0000;
    checks++; if (busy !== 1'b1 || slot_busy !== 4'b0000) begin failures++; $display("FAIL drain_hold busy=%b slots=%b exp=1,0000", busy, slot_busy); end
    tick();
    trigger = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_idle got=%b exp=0", busy); end
    checks++; if (pass_count !== 16'd3 || drop_count !== 16'd0) begin failures++; $display("FAIL drain_counts pass=%0d drop=%0d exp=3,0", pass_count, drop_count); end
    $display("test_drain done");
  endtask

  task automatic test_async_reset();
    enable = 1'b1; trigger = 1'b1;
    tick(); tick(); tick();
    trigger = 1'b0;
    checks++; if (slot_busy !== 4'b0111) begin failures++; $display("FAIL prereset_busy got=%b exp=0111", slot_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (slot_busy !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL async_reset_slots slots=%b busy=%b exp=0", slot_busy, busy); end
    checks++; if (pass_count !== 16'd0 || timeout_count !== 16'd0 || any_fail !== 1'b0) begin failures++; $display("FAIL async_reset_counts pass=%0d timeout=%0d any_fail=%b exp=0", pass_count, timeout_count, any_fail); end
    enable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (slot_abort !== 4'b0000) begin failures++; $display("FAIL post_reset_abort%0d got=%b exp=0000", k, slot_abort); end
    end
    checks++; if (timeout_count !== 16'd0 || slot_busy !== 4'b0000) begin failures++; $display("FAIL post_reset_state timeout=%0d slots=%b exp=0", timeout_count, slot_busy); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_dual_fail();
    test_timeout();
    test_drain();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
